// File: rtl/branch_target_predictor_if.sv
// Fetch-lookup / EX-resolve bundle between the pipeline (master) and the branch target predictor (slave).
// Stat_* members exist only when BTP_STATS_EN is defined.
interface branch_target_predictor_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] IF_PC;
    logic              Pred_Taken;
    logic [ADDR_W-1:0] Pred_Target;
    logic              EX_Valid;
    logic [ADDR_W-1:0] EX_PC;
    logic [ADDR_W-1:0] EX_Target;
    logic              EX_Taken;
    logic              EX_PredTaken;
    logic [ADDR_W-1:0] EX_PredTarget;
    logic              Mispredict;
    logic [ADDR_W-1:0] Redirect_PC;
    logic              BTB_Clear;
`ifdef BTP_STATS_EN
    logic [31:0]       Stat_Branches;
    logic [31:0]       Stat_Mispredicts;
`endif

    modport master (
        output IF_PC, EX_Valid, EX_PC, EX_Target, EX_Taken, EX_PredTaken, EX_PredTarget, BTB_Clear,
        input  Pred_Taken, Pred_Target, Mispredict, Redirect_PC
`ifdef BTP_STATS_EN
        ,
        input  Stat_Branches, Stat_Mispredicts
`endif
    );

    modport slave (
        input  IF_PC, EX_Valid, EX_PC, EX_Target, EX_Taken, EX_PredTaken, EX_PredTarget, BTB_Clear,
        output Pred_Taken, Pred_Target, Mispredict, Redirect_PC
`ifdef BTP_STATS_EN
        ,
        output Stat_Branches, Stat_Mispredicts
`endif
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional BTP_STATS_EN adds saturating branch / mispredict statistics counters.
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32
) (
    input logic                       Clk,
    input logic                       Reset,
    branch_target_predictor_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0]   if_idx;
    logic [TAG_W-1:0]   if_tag;
    logic               if_hit;
    logic               pred_taken;
    logic [IDX_W-1:0]   ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic [3:0]         unused_pc_bits;

    // Instructions are word aligned, so the byte offset never selects an entry.
    assign unused_pc_bits = {bus.IF_PC[1:0], bus.EX_PC[1:0]};

    assign if_idx = bus.IF_PC[IDX_W+1:2];
    assign if_tag = bus.IF_PC[ADDR_W-1:IDX_W+2];
    assign ex_idx = bus.EX_PC[IDX_W+1:2];
    assign ex_tag = bus.EX_PC[ADDR_W-1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is not visible until the next cycle.
    always_comb begin
        if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken = if_hit && ctr_q[if_idx][1];
        ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    end

    assign bus.Pred_Taken  = pred_taken;
    assign bus.Pred_Target = pred_taken ? target_q[if_idx] : bus.IF_PC + ADDR_W'(4);

    assign bus.Mispredict  = bus.EX_Valid &&
                             ((bus.EX_Taken != bus.EX_PredTaken) ||
                              (bus.EX_Taken && (bus.EX_Target != bus.EX_PredTarget)));
    assign bus.Redirect_PC = bus.EX_Taken ? bus.EX_Target : bus.EX_PC + ADDR_W'(4);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (bus.BTB_Clear) begin
            valid_q <= '0;
        end else if (bus.EX_Valid) begin
            if (ex_hit) begin
                if (bus.EX_Taken) begin
                    if (ctr_q[ex_idx] != 2'b11) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    end
                    target_q[ex_idx] <= bus.EX_Target;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end else if (bus.EX_Taken) begin
                // Miss on a taken branch replaces whatever aliased into this slot, weakly taken.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= bus.EX_Target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

`ifdef BTP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    // Statistics survive BTB_Clear; only reset zeroes them.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (bus.EX_Valid && (stat_branches_q != 32'hFFFF_FFFF)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (bus.Mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign bus.Stat_Branches    = stat_branches_q;
    assign bus.Stat_Mispredicts = stat_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed scenarios plus randomized traffic
// compared against an arithmetic table model.
module tb_branch_target_predictor;
    localparam int ENTRIES = 16;
    localparam int ADDR_W  = 32;

    logic Clk;
    logic Reset;

    branch_target_predictor_if #(.ADDR_W(ADDR_W)) bus ();

    branch_target_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_valid [ENTRIES];
    longint      m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_branches;
    longint      m_misp;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic int idx_of(logic [31:0] pc);
        return int'((longint'(pc) / 4) % ENTRIES);
    endfunction

    function automatic longint tag_of(logic [31:0] pc);
        return longint'(pc) / (4 * ENTRIES);
    endfunction

    function automatic logic [31:0] plus4(logic [31:0] pc);
        return 32'((longint'(pc) + 4) % 64'h1_0000_0000);
    endfunction

    function automatic bit m_pred_taken(logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : plus4(pc);
    endfunction

    function automatic bit exp_misp();
        if (!bus.EX_Valid) return 1'b0;
        if (bus.EX_Taken != bus.EX_PredTaken) return 1'b1;
        return bus.EX_Taken && (bus.EX_Target != bus.EX_PredTarget);
    endfunction

    function automatic logic [31:0] exp_redirect();
        return bus.EX_Taken ? bus.EX_Target : plus4(bus.EX_PC);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 1'b0;
            m_tag[k]   = 0;
            m_tgt[k]   = '0;
            m_ctr[k]   = 1;
        end
        m_branches = 0;
        m_misp     = 0;
    endtask

    task automatic model_edge();
        int  i;
        bit  h;
        if (bus.EX_Valid && m_branches < 64'hFFFF_FFFF) m_branches++;
        if (exp_misp() && m_misp < 64'hFFFF_FFFF) m_misp++;
        if (bus.BTB_Clear) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
            return;
        end
        if (!bus.EX_Valid) return;
        i = idx_of(bus.EX_PC);
        h = m_valid[i] && (m_tag[i] == tag_of(bus.EX_PC));
        if (h) begin
            if (bus.EX_Taken) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = bus.EX_Target;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (bus.EX_Taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = tag_of(bus.EX_PC);
            m_tgt[i]   = bus.EX_Target;
            m_ctr[i]   = 2;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset) model_edge();
        #1;
    endtask

    task automatic idle();
        bus.EX_Valid      = 1'b0;
        bus.EX_PC         = '0;
        bus.EX_Target     = '0;
        bus.EX_Taken      = 1'b0;
        bus.EX_PredTaken  = 1'b0;
        bus.EX_PredTarget = '0;
        bus.BTB_Clear     = 1'b0;
    endtask

    task automatic set_ex(logic [31:0] pc, logic [31:0] tgt, bit tk, bit ptk, logic [31:0] ptgt);
        bus.EX_Valid      = 1'b1;
        bus.EX_PC         = pc;
        bus.EX_Target     = tgt;
        bus.EX_Taken      = tk;
        bus.EX_PredTaken  = ptk;
        bus.EX_PredTarget = ptgt;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        idle();
        model_reset();
        bus.IF_PC = 32'h0040_0010;
        #3;
        if (bus.Pred_Taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_pred_taken got=%b exp=0", bus.Pred_Taken);
        end
        n_checks++;
        if (bus.Pred_Target !== 32'h0040_0014) begin
            n_fail++; $display("FAIL reset_pred_target got=%h exp=00400014", bus.Pred_Target);
        end
        n_checks++;
        set_ex(32'h0040_0010, 32'h0040_0040, 1'b1, 1'b0, 32'h0);
        #1;
        if (bus.Mispredict !== 1'b1 || bus.Redirect_PC !== 32'h0040_0040) begin
            n_fail++; $display("FAIL reset_comb_misp got=%b/%h exp=1/00400040", bus.Mispredict, bus.Redirect_PC);
        end
        n_checks++;
        tick();
        if (bus.Pred_Taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold_pred got=%b exp=0", bus.Pred_Taken);
        end
        n_checks++;
        idle();
        @(negedge Clk);
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_train();
        bus.IF_PC = 32'h0040_0010;
        set_ex(32'h0040_0010, 32'h0040_0040, 1'b1, 1'b0, 32'h0);
        @(negedge Clk);
        if (bus.Mispredict !== 1'b1) begin
            n_fail++; $display("FAIL train_misp got=%b exp=1", bus.Mispredict);
        end
        n_checks++;
        if (bus.Redirect_PC !== 32'h0040_0040) begin
            n_fail++; $display("FAIL train_redirect got=%h exp=00400040", bus.Redirect_PC);
        end
        n_checks++;
        if (bus.Pred_Taken !== 1'b0) begin
            n_fail++; $display("FAIL train_same_cycle got=%b exp=0", bus.Pred_Taken);
        end
        n_checks++;
        tick();
        idle();
        @(negedge Clk);
        if (bus.Pred_Taken !== 1'b1 || bus.Pred_Target !== 32'h0040_0040) begin
            n_fail++; $display("FAIL train_lookup got=%b/%h exp=1/00400040", bus.Pred_Taken, bus.Pred_Target);
        end
        n_checks++;
        tick();
    endtask

    task automatic test_counter();
        bit op_tk  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit exp_pt [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            bus.IF_PC = 32'h0040_0010;
            set_ex(32'h0040_0010, 32'h0040_0040, op_tk[k], 1'b0, 32'h0);
            @(negedge Clk);
            if (bus.Mispredict !== op_tk[k]) begin
                n_fail++; $display("FAIL counter_misp op=%0d got=%b exp=%b", k, bus.Mispredict, op_tk[k]);
            end
            n_checks++;
            if (bus.Redirect_PC !== (op_tk[k] ? 32'h0040_0040 : 32'h0040_0014)) begin
                n_fail++; $display("FAIL counter_redirect op=%0d got=%h", k, bus.Redirect_PC);
            end
            n_checks++;
            tick();
            idle();
            @(negedge Clk);
            if (bus.Pred_Taken !== exp_pt[k]) begin
                n_fail++; $display("FAIL counter_pred op=%0d got=%b exp=%b", k, bus.Pred_Taken, exp_pt[k]);
            end
            n_checks++;
            tick();
        end
    endtask

    task automatic test_alias();
        set_ex(32'h0040_0050, 32'h0040_0080, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        set_ex(32'h0040_0090, 32'h0040_00C0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        bus.IF_PC = 32'h0040_0010;
        @(negedge Clk);
        if (bus.Pred_Taken !== 1'b0 || bus.Pred_Target !== 32'h0040_0014) begin
            n_fail++; $display("FAIL alias_old_miss got=%b/%h exp=0/00400014", bus.Pred_Taken, bus.Pred_Target);
        end
        n_checks++;
        bus.IF_PC = 32'h0040_0050;
        #1;
        if (bus.Pred_Taken !== 1'b1 || bus.Pred_Target !== 32'h0040_0080) begin
            n_fail++; $display("FAIL alias_new_hit got=%b/%h exp=1/00400080", bus.Pred_Taken, bus.Pred_Target);
        end
        n_checks++;
        tick();
    endtask

    task automatic test_rbw_clear();
        bus.IF_PC = 32'h0040_0050;
        set_ex(32'h0040_0050, 32'h0040_0080, 1'b0, 1'b1, 32'h0040_0080);
        @(negedge Clk);
        if (bus.Pred_Taken !== 1'b1) begin
            n_fail++; $display("FAIL rbw_old_state got=%b exp=1", bus.Pred_Taken);
        end
        n_checks++;
        tick();
        idle();
        @(negedge Clk);
        if (bus.Pred_Taken !== 1'b0) begin
            n_fail++; $display("FAIL rbw_new_state got=%b exp=0", bus.Pred_Taken);
        end
        n_checks++;
        tick();
        set_ex(32'h0040_0020, 32'h0040_0100, 1'b1, 1'b0, 32'h0);
        tick();
        set_ex(32'h0040_0050, 32'h0040_0080, 1'b1, 1'b0, 32'h0);
        bus.BTB_Clear = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 2; k++) begin
            bus.IF_PC = (k == 0) ? 32'h0040_0020 : 32'h0040_0050;
            #1;
            if (bus.Pred_Taken !== 1'b0 || bus.Pred_Target !== bus.IF_PC + 32'd4) begin
                n_fail++; $display("FAIL clear_miss pc=%h got=%b/%h", bus.IF_PC, bus.Pred_Taken, bus.Pred_Target);
            end
            n_checks++;
        end
        tick();
    endtask

    task automatic test_wrap();
        bus.IF_PC = 32'hFFFF_FFFC;
        set_ex(32'hFFFF_FFFC, 32'h0000_1000, 1'b0, 1'b1, 32'h0000_1000);
        @(negedge Clk);
        if (bus.Mispredict !== 1'b1 || bus.Redirect_PC !== 32'h0) begin
            n_fail++; $display("FAIL wrap_redirect got=%b/%h exp=1/00000000", bus.Mispredict, bus.Redirect_PC);
        end
        n_checks++;
        if (bus.Pred_Target !== 32'h0) begin
            n_fail++; $display("FAIL wrap_pred_target got=%h exp=00000000", bus.Pred_Target);
        end
        n_checks++;
        tick();
        idle();
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0040_0000;
            1:       base = 32'h0080_0000;
            default: base = 32'hFFFF_FF00;
        endcase
        return base + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        bit          e_tk;
        logic [31:0] e_tg;
        for (int c = 0; c < 400; c++) begin
            idle();
            bus.IF_PC = rand_pc();
            if ($urandom_range(0, 3) != 0) begin
                bus.EX_Valid  = 1'b1;
                bus.EX_PC     = rand_pc();
                bus.EX_Target = rand_pc();
                bus.EX_Taken  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) != 0) begin
                    bus.EX_PredTaken  = m_pred_taken(bus.EX_PC);
                    bus.EX_PredTarget = m_pred_target(bus.EX_PC);
                end else begin
                    bus.EX_PredTaken  = 1'($urandom_range(0, 1));
                    bus.EX_PredTarget = ($urandom_range(0, 1) != 0) ? bus.EX_Target : rand_pc();
                end
            end
            bus.BTB_Clear = ($urandom_range(0, 24) == 0);
            e_tk = m_pred_taken(bus.IF_PC);
            e_tg = m_pred_target(bus.IF_PC);
            @(negedge Clk);
            if (bus.Pred_Taken !== e_tk) begin
                n_fail++; $display("FAIL rand_pred_taken c=%0d pc=%h got=%b exp=%b", c, bus.IF_PC, bus.Pred_Taken, e_tk);
            end
            n_checks++;
            if (bus.Pred_Target !== e_tg) begin
                n_fail++; $display("FAIL rand_pred_target c=%0d pc=%h got=%h exp=%h", c, bus.IF_PC, bus.Pred_Target, e_tg);
            end
            n_checks++;
            if (bus.Mispredict !== exp_misp()) begin
                n_fail++; $display("FAIL rand_misp c=%0d got=%b exp=%b", c, bus.Mispredict, exp_misp());
            end
            n_checks++;
            if (bus.Redirect_PC !== exp_redirect()) begin
                n_fail++; $display("FAIL rand_redirect c=%0d got=%h exp=%h", c, bus.Redirect_PC, exp_redirect());
            end
            n_checks++;
            tick();
        end
        idle();
`ifdef BTP_STATS_EN
        @(negedge Clk);
        if (bus.Stat_Branches !== 32'(m_branches) || bus.Stat_Mispredicts !== 32'(m_misp)) begin
            n_fail++; $display("FAIL rand_stats got=%0d/%0d exp=%0d/%0d", bus.Stat_Branches, bus.Stat_Mispredicts, m_branches, m_misp);
        end
        n_checks++;
        tick();
`endif
    endtask

    task automatic test_reset_mid_update();
        bus.IF_PC = 32'h0040_0100;
        set_ex(32'h0040_0100, 32'h0040_0200, 1'b1, 1'b0, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        tick();
        if (bus.Pred_Taken !== 1'b0 || bus.Pred_Target !== 32'h0040_0104) begin
            n_fail++; $display("FAIL reset_mid_hold got=%b/%h exp=0/00400104", bus.Pred_Taken, bus.Pred_Target);
        end
        n_checks++;
        idle();
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        if (bus.Pred_Taken !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_discard got=%b exp=0", bus.Pred_Taken);
        end
        n_checks++;
    endtask

`ifdef BTP_STATS_EN
    task automatic test_stats();
        bit          s_tk  [3] = '{1'b1, 1'b1, 1'b0};
        bit          s_ptk [3] = '{1'b0, 1'b1, 1'b0};
        idle();
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        #1;
        if (bus.Stat_Branches !== 32'd0 || bus.Stat_Mispredicts !== 32'd0) begin
            n_fail++; $display("FAIL stats_reset got=%0d/%0d exp=0/0", bus.Stat_Branches, bus.Stat_Mispredicts);
        end
        n_checks++;
        @(negedge Clk);
        Reset = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            set_ex(32'h0040_0300, 32'h0040_0400, s_tk[k], s_ptk[k], 32'h0040_0400);
            tick();
            idle();
            bus.BTB_Clear = (k == 1);
            tick();
            bus.BTB_Clear = 1'b0;
        end
        if (bus.Stat_Branches !== 32'd3 || bus.Stat_Mispredicts !== 32'd1) begin
            n_fail++; $display("FAIL stats_count got=%0d/%0d exp=3/1", bus.Stat_Branches, bus.Stat_Mispredicts);
        end
        n_checks++;
        set_ex(32'h0040_0300, 32'h0040_0400, 1'b1, 1'b0, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        tick();
        if (bus.Stat_Branches !== 32'd0 || bus.Stat_Mispredicts !== 32'd0) begin
            n_fail++; $display("FAIL stats_mid_reset got=%0d/%0d exp=0/0", bus.Stat_Branches, bus.Stat_Mispredicts);
        end
        n_checks++;
        idle();
        @(negedge Clk);
        Reset = 1'b1;
        tick();
    endtask
`endif

    initial begin
        Reset     = 1'b0;
        bus.IF_PC = '0;
        idle();
        test_reset();
        test_train();
        test_counter();
        test_alias();
        test_rbw_clear();
        test_wrap();
        test_random();
        test_reset_mid_update();
`ifdef BTP_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16: number of table entries; power of two, minimum 2.
REQ-002 SHALL provide parameter ADDR_W, default 32: PC and target width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: Clk  in  1  rising-edge clock.
REQ-005 Port: Reset  in  1  asynchronous active-low reset.
REQ-006 Port: IF_PC  in  ADDR_W  fetch-stage PC to look up.
REQ-007 Port: Pred_Taken  out  1  prediction for IF_PC; 1 means taken.
REQ-008 Port: Pred_Target  out  ADDR_W  predicted target; IF_PC+4 when Pred_Taken=0.
REQ-009 Port: EX_Valid  in  1  a resolved branch or jump is present in EX this cycle.
REQ-010 Port: EX_PC, EX_Target  in  ADDR_W each  resolved instruction's PC and its taken target.
REQ-011 Port: EX_Taken  in  1  resolved direction (1 for j/jal/jr).
REQ-012 Port: EX_PredTaken, EX_PredTarget  in  1, ADDR_W  prediction carried down the pipeline with the instruction.
REQ-013 Port: Mispredict  out  1  EX must flush IF/ID and ID/EX.
REQ-014 Port: Redirect_PC  out  ADDR_W  correct next PC when Mispredict=1.
REQ-015 Port: BTB_Clear  in  1  synchronous invalidate of all entries.

Function
REQ-016 Index = PC[log2(ENTRIES)+1:2]; tag = PC[ADDR_W-1:log2(ENTRIES)+2]; PC[1:0] ignored.
REQ-017 Each entry holds a valid bit, a tag, a target and a 2-bit saturating counter.
REQ-018 Lookup is combinational: hit = valid & tag match; Pred_Taken = hit & counter[1].
REQ-019 Mispredict = EX_Valid & (EX_Taken != EX_PredTaken | (EX_Taken & EX_Target != EX_PredTarget)); combinational.
REQ-020 Redirect_PC = EX_Taken ? EX_Target : EX_PC+4; addition wraps modulo 2^ADDR_W.
REQ-021 Update occurs on the rising edge when EX_Valid=1.
REQ-022 On update hit: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00; target is rewritten only when taken.
REQ-023 On update miss and taken: allocate the entry at the index (overwrite), counter=10, target=EX_Target.
REQ-024 On update miss and not taken: no table change.
REQ-025 Same-cycle lookup and update of one index: the lookup returns pre-update contents (read-before-write).
REQ-026 BTB_Clear=1 clears all valid bits at the next edge and takes priority over a coincident update.
REQ-027 Latency: a trained entry affects Pred_Taken starting the cycle after the update edge.

Reset
REQ-028 Reset low asynchronously clears all valid bits, sets all counters to 01, and zeroes targets and statistics counters.
REQ-029 During and after reset Pred_Taken=0 and Pred_Target=IF_PC+4; Mispredict and Redirect_PC depend only on inputs.
REQ-030 Reset asserted mid-update: the update is discarded and the reset state holds.

Configuration
REQ-031 Macro BTP_STATS_EN defined: adds outputs Stat_Branches (32 bits, +1 per EX_Valid edge) and Stat_Mispredicts (32 bits, +1 per edge with Mispredict=1); both saturate at 0xFFFFFFFF, are unaffected by BTB_Clear, and are cleared by reset.
REQ-032 Macro BTP_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 After reset, IF_PC=0x00400010 -> Pred_Taken=0, Pred_Target=0x00400014.
REQ-034 Taken update EX_PC=0x00400010, EX_Target=0x00400040, EX_PredTaken=0 -> Mispredict=1, Redirect_PC=0x00400040; next cycle, a lookup of 0x00400010 gives Pred_Taken=1, Pred_Target=0x00400040.
REQ-035 Two not-taken updates on that entry -> counter 10->01->00; lookup gives Pred_Taken=0; a further not-taken keeps 00; one taken gives 01, still predicting not-taken.
REQ-036 Alias test (ENTRIES=16): train 0x00400010, then a taken update at 0x00400050 -> entry replaced; lookup of 0x00400010 misses.
REQ-037 Same-cycle lookup and update of one index -> Pred_Taken reflects old state; BTB_Clear together with an update -> all lookups miss next cycle.
REQ-038 With BTP_STATS_EN: 3 updates with 1 mispredict -> Stat_Branches=3, Stat_Mispredicts=1; reset mid-run -> both 0.
